// File: rtl/a2_fetch_stage.sv
// a2_fetch_stage: PC owner and IF/ID register with stall, flush and branch redirect.
// Define FETCH_HALT_EN to enable halting on HALT_OPCODE.
module a2_fetch_stage #(
  parameter int              ADDR_W      = 8,
  parameter int              INSTR_W     = 8,
  parameter int              MEM_DEPTH   = 6,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_in_range;
  logic              w_halt_en;
  logic              w_halt_hit;
  logic              r_halted;
`ifdef FETCH_HALT_EN
  assign w_halt_en = 1'b1;
`else
  assign w_halt_en = 1'b0;
`endif
  assign imem_address = r_pc;
  assign w_in_range   = r_pc <= LAST;
  // out-of-range PCs also fold back to 0
  assign w_next_pc    = (r_pc >= LAST) ? '0 : r_pc + ADDR_W'(1);
  assign w_halt_hit   = w_halt_en && (imem_instruction == HALT_OPCODE);
  assign halted       = r_halted;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc             <= '0;
      ifid_instruction <= NOP_INSTR;
      ifid_pc          <= '0;
      ifid_valid       <= 1'b0;
      r_halted         <= 1'b0;
    end else if (branch_taken) begin
      r_pc             <= branch_target;
      ifid_instruction <= NOP_INSTR;
      ifid_pc          <= '0;
      ifid_valid       <= 1'b0;
      r_halted         <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        ifid_instruction <= NOP_INSTR;
        ifid_pc          <= '0;
        ifid_valid       <= 1'b0;
      end
    end else if (flush || r_halted || !w_in_range) begin
      r_pc             <= r_halted ? r_pc : w_next_pc;
      ifid_instruction <= NOP_INSTR;
      ifid_pc          <= '0;
      ifid_valid       <= 1'b0;
    end else begin
      r_pc             <= w_halt_hit ? r_pc : w_next_pc;
      ifid_instruction <= imem_instruction;
      ifid_pc          <= r_pc;
      ifid_valid       <= 1'b1;
      r_halted         <= w_halt_hit;
    end
  end
endmodule

// File: tb/tb_a2_fetch_stage.sv
// tb_a2_fetch_stage: directed checks of fetch sequencing, stall, flush, redirect and halt.
module tb_a2_fetch_stage;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] imem_address;
  logic [7:0] imem_instruction;
  logic [7:0] ifid_instruction;
  logic [7:0] ifid_pc;
  logic       ifid_valid;
  logic       halted;
  logic [7:0] mem [6];
  logic [25:0] obs;
  logic [25:0] e;
  int vectors = 0;
  int miscompares = 0;

  a2_fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .ifid_instruction(ifid_instruction), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clock = ~clock;
  assign imem_instruction = (imem_address < 8'd6) ? mem[imem_address[2:0]] : 8'hEE;
  assign obs = {ifid_instruction, ifid_pc, ifid_valid, imem_address, halted};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #4;
    e = {8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_state: got %h expected %h", obs, e); end
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_free_run;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = {mem[k % 6], 8'(k % 6), 1'b1, 8'((k + 1) % 6), 1'b0};
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL free_run step %0d: got %h expected %h", k, obs, e); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = {8'h22, 8'd1, 1'b1, 8'd2, 1'b0};
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL stall_hold step %0d: got %h expected %h", k, obs, e); end
    end
    stall = 1'b0;
    tick();
    e = {8'h33, 8'd2, 1'b1, 8'd3, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL stall_release: got %h expected %h", obs, e); end
  endtask

  task automatic test_flush;
    logic [25:0] exp_seq [4];
    exp_seq[0] = {8'h00, 8'd0, 1'b0, 8'd4, 1'b0};
    exp_seq[1] = {8'h55, 8'd4, 1'b1, 8'd5, 1'b0};
    exp_seq[2] = {8'h66, 8'd5, 1'b1, 8'd0, 1'b0};
    exp_seq[3] = {8'h11, 8'd0, 1'b1, 8'd1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      flush = (k == 0);
      tick();
      vectors++;
      if (obs !== exp_seq[k]) begin miscompares++; $display("FAIL flush step %0d: got %h expected %h", k, obs, exp_seq[k]); end
    end
    flush = 1'b0;
  endtask

  task automatic test_branch_over_stall;
    branch_taken = 1'b1; branch_target = 8'd4; stall = 1'b1; flush = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
    e = {8'h00, 8'd0, 1'b0, 8'd4, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL branch_redirect: got %h expected %h", obs, e); end
    tick();
    e = {8'h55, 8'd4, 1'b1, 8'd5, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL branch_capture: got %h expected %h", obs, e); end
  endtask

  task automatic test_out_of_range;
    logic [25:0] exp_seq [3];
    exp_seq[0] = {8'h00, 8'd0, 1'b0, 8'd7, 1'b0};
    exp_seq[1] = {8'h00, 8'd0, 1'b0, 8'd0, 1'b0};
    exp_seq[2] = {8'h11, 8'd0, 1'b1, 8'd1, 1'b0};
    branch_taken = 1'b1; branch_target = 8'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      branch_taken = 1'b0;
      vectors++;
      if (obs !== exp_seq[k]) begin miscompares++; $display("FAIL out_of_range step %0d: got %h expected %h", k, obs, exp_seq[k]); end
    end
  endtask

  task automatic test_halt;
    mem[2] = 8'hFF;
    tick();
    e = {8'h22, 8'd1, 1'b1, 8'd2, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_pre: got %h expected %h", obs, e); end
`ifdef FETCH_HALT_EN
    tick();
    e = {8'hFF, 8'd2, 1'b1, 8'd2, 1'b1};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_capture: got %h expected %h", obs, e); end
    for (int k = 0; k < 2; k++) begin
      tick();
      e = {8'h00, 8'd0, 1'b0, 8'd2, 1'b1};
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL halt_bubble step %0d: got %h expected %h", k, obs, e); end
    end
    branch_taken = 1'b1; branch_target = 8'd0;
    tick();
    branch_taken = 1'b0;
    e = {8'h00, 8'd0, 1'b0, 8'd0, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_clear: got %h expected %h", obs, e); end
    tick();
    tick();
    e = {8'h22, 8'd1, 1'b1, 8'd2, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_resume: got %h expected %h", obs, e); end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_stalled: got %h expected %h", obs, e); end
`else
    tick();
    e = {8'hFF, 8'd2, 1'b1, 8'd3, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_ignored: got %h expected %h", obs, e); end
    tick();
    e = {8'h44, 8'd3, 1'b1, 8'd4, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL halt_flow: got %h expected %h", obs, e); end
`endif
    mem[2] = 8'h33;
  endtask

  task automatic test_async_reset;
    stall = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    e = {8'h00, 8'd0, 1'b0, 8'd0, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL async_reset: got %h expected %h", obs, e); end
    @(negedge clock);
    reset = 1'b1; stall = 1'b0;
    tick();
    e = {8'h11, 8'd0, 1'b1, 8'd1, 1'b0};
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_restart: got %h expected %h", obs, e); end
  endtask

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_branch_over_stall();
    test_out_of_range();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
